// File: rtl/msrh_bim_update_gen_pkg.sv
// Shared types and helpers for the bimodal-counter update path.
//   VADDR_W          : virtual PC width
//   BTB_ENTRY_SIZE   : number of bimodal counters (index = pc[IDX_W:1])
//   bim_upd_entry_t  : one queued resolved-branch record
//   bim_next_counter : counter update rule, shared with the predictor so
//                      both ends apply identical 2-bit arithmetic
package msrh_bim_update_gen_pkg;

    localparam int VADDR_W        = 39;
    localparam int BTB_ENTRY_SIZE = 64;
    localparam int IDX_W          = $clog2(BTB_ENTRY_SIZE);

    typedef struct packed {
        logic [VADDR_W-1:0] pc_vaddr;
        logic               taken;
        logic               mispred;
        logic [1:0]         bim_value;
    } bim_upd_entry_t;

    // Hold when the prediction was correct and the counter is already
    // saturated; otherwise step toward the actual direction. The step wraps
    // in 2 bits, matching the predictor's array write.
    function automatic logic [1:0] bim_next_counter(input logic [1:0] value,
                                                    input logic       hit,
                                                    input logic       taken);
        if (hit && (value == 2'b00 || value == 2'b11)) begin
            return value;
        end else if (taken) begin
            return value + 2'd1;
        end else begin
            return value - 2'd1;
        end
    endfunction

endpackage

// File: rtl/msrh_bim_upd_fifo.sv
// Generic multi-push, single-pop FIFO.
//   i_clk, i_reset : clock, synchronous active-high reset
//   i_push_valid   : per-slot push request; valid slots are compacted in
//                    slot order (slot 0 lands first)
//   i_push_data    : per-slot payload
//   i_pop          : remove the head entry (ignored when empty)
//   o_head         : head entry, combinational from the head pointer
//   o_empty        : no entries stored
//   o_ready        : at least BR_WIDTH free entries (from registered count)
module msrh_bim_upd_fifo #(
    parameter type T          = logic,
    parameter int  BR_WIDTH   = 2,
    parameter int  FIFO_DEPTH = 4
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic [BR_WIDTH-1:0] i_push_valid,
    input  T                    i_push_data [BR_WIDTH],
    input  logic                i_pop,
    output T                    o_head,
    output logic                o_empty,
    output logic                o_ready
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    T                   mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]   head_q;
    logic [PTR_W-1:0]   tail_q;
    logic [CNT_W-1:0]   count_q;

    logic [BR_WIDTH-1:0] push_en;
    logic [PTR_W-1:0]    wr_ptr [BR_WIDTH];
    logic [CNT_W-1:0]    push_cnt;
    logic                pop_en;

    assign o_empty = (count_q == '0);
    assign o_ready = (CNT_W'(FIFO_DEPTH) - count_q) >= CNT_W'(BR_WIDTH);
    assign o_head  = mem_q[head_q];
    assign pop_en  = i_pop && !o_empty;

    // Each valid slot writes at tail plus the number of older valid slots.
    always_comb begin
        push_cnt = '0;
        for (int i = 0; i < BR_WIDTH; i++) begin
            push_en[i] = i_push_valid[i] & o_ready;
            wr_ptr[i]  = tail_q + push_cnt[PTR_W-1:0];
            push_cnt   = push_cnt + CNT_W'(push_en[i]);
        end
    end

    always_ff @(posedge i_clk) begin
        for (int i = 0; i < BR_WIDTH; i++) begin
            if (push_en[i]) begin
                mem_q[wr_ptr[i]] <= i_push_data[i];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            tail_q  <= tail_q + push_cnt[PTR_W-1:0];
            head_q  <= head_q + PTR_W'(pop_en);
            count_q <= count_q + push_cnt - CNT_W'(pop_en);
        end
    end

endmodule

// File: rtl/msrh_bim_update_gen.sv
// Master side of the bimodal-counter update interface. Resolved conditional
// branches are queued and issued one per cycle to the bimodal predictor.
//   i_clk, i_reset        : clock, synchronous active-high reset
//   i_br_*                : per-slot resolved branches (slot 0 older);
//                           accepted only while o_br_ready=1
//   o_br_ready            : at least BR_WIDTH free queue entries
//   o_update_bim_*        : update_bim_if master (valid, pc_vaddr, taken,
//                           hit, bim_value); every valid cycle is consumed
//   o_fifo_empty          : queue empty, for drain/fence
// Build option MSRH_BIM_UPDATE_FWD_EN: when defined, an update that hits the
// same counter index as the previous cycle's update carries the counter that
// update wrote instead of the stale prediction-time value.
module msrh_bim_update_gen
    import msrh_bim_update_gen_pkg::*;
#(
    parameter int BR_WIDTH   = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                              i_clk,
    input  logic                              i_reset,
    input  logic [BR_WIDTH-1:0]               i_br_valid,
    input  logic [BR_WIDTH-1:0][VADDR_W-1:0]  i_br_pc_vaddr,
    input  logic [BR_WIDTH-1:0]               i_br_taken,
    input  logic [BR_WIDTH-1:0]               i_br_mispred,
    input  logic [BR_WIDTH-1:0][1:0]          i_br_bim_value,
    output logic                              o_br_ready,
    output logic                              o_update_bim_valid,
    output logic [VADDR_W-1:0]                o_update_bim_pc_vaddr,
    output logic                              o_update_bim_taken,
    output logic                              o_update_bim_hit,
    output logic [1:0]                        o_update_bim_bim_value,
    output logic                              o_fifo_empty
);

    bim_upd_entry_t push_data [BR_WIDTH];
    bim_upd_entry_t head;
    logic           fifo_empty;

    always_comb begin
        for (int i = 0; i < BR_WIDTH; i++) begin
            push_data[i].pc_vaddr  = i_br_pc_vaddr[i];
            push_data[i].taken     = i_br_taken[i];
            push_data[i].mispred   = i_br_mispred[i];
            push_data[i].bim_value = i_br_bim_value[i];
        end
    end

    msrh_bim_upd_fifo #(
        .T          (bim_upd_entry_t),
        .BR_WIDTH   (BR_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_push_valid (i_br_valid),
        .i_push_data  (push_data),
        .i_pop        (!fifo_empty),
        .o_head       (head),
        .o_empty      (fifo_empty),
        .o_ready      (o_br_ready)
    );

    assign o_update_bim_valid    = !fifo_empty;
    assign o_update_bim_pc_vaddr = head.pc_vaddr;
    assign o_update_bim_taken    = head.taken;
    assign o_update_bim_hit      = !head.mispred;
    assign o_fifo_empty          = fifo_empty;

`ifdef MSRH_BIM_UPDATE_FWD_EN
    logic             r_last_valid_q;
    logic [IDX_W-1:0] r_last_idx_q;
    logic [1:0]       r_last_val_q;
    logic [IDX_W-1:0] head_idx;

    assign head_idx = head.pc_vaddr[IDX_W:1];

    assign o_update_bim_bim_value =
        (r_last_valid_q && (head_idx == r_last_idx_q)) ? r_last_val_q : head.bim_value;

    // Track what the predictor writes this cycle, computed from the value
    // actually issued (which may itself be forwarded).
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_last_valid_q <= 1'b0;
        end else begin
            r_last_valid_q <= o_update_bim_valid;
            r_last_idx_q   <= head_idx;
            r_last_val_q   <= bim_next_counter(o_update_bim_bim_value,
                                               !head.mispred, head.taken);
        end
    end
`else
    assign o_update_bim_bim_value = head.bim_value;
`endif

`ifndef SYNTHESIS
    // Slots presented while not ready are dropped by the queue.
    a_no_push_when_full: assert property (@(posedge i_clk) disable iff (i_reset)
        !((|i_br_valid) && !o_br_ready));
`endif

endmodule

// File: tb/tb_msrh_bim_update_gen.sv
module tb_msrh_bim_update_gen;
    import msrh_bim_update_gen_pkg::*;

    localparam int BRW   = 2;
    localparam int DEPTH = 4;
    localparam int IW    = IDX_W;
`ifdef MSRH_BIM_UPDATE_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                        rst = 1'b1;
    logic [BRW-1:0]              br_valid = '0;
    logic [BRW-1:0][VADDR_W-1:0] br_pc = '0;
    logic [BRW-1:0]              br_taken = '0;
    logic [BRW-1:0]              br_mispred = '0;
    logic [BRW-1:0][1:0]         br_bim = '0;
    logic                        br_ready;
    logic                        upd_valid;
    logic [VADDR_W-1:0]          upd_pc;
    logic                        upd_taken;
    logic                        upd_hit;
    logic [1:0]                  upd_bim;
    logic                        fifo_empty;

    msrh_bim_update_gen #(.BR_WIDTH(BRW), .FIFO_DEPTH(DEPTH)) dut (
        .i_clk                  (clk),
        .i_reset                (rst),
        .i_br_valid             (br_valid),
        .i_br_pc_vaddr          (br_pc),
        .i_br_taken             (br_taken),
        .i_br_mispred           (br_mispred),
        .i_br_bim_value         (br_bim),
        .o_br_ready             (br_ready),
        .o_update_bim_valid     (upd_valid),
        .o_update_bim_pc_vaddr  (upd_pc),
        .o_update_bim_taken     (upd_taken),
        .o_update_bim_hit       (upd_hit),
        .o_update_bim_bim_value (upd_bim),
        .o_fifo_empty           (fifo_empty)
    );

    typedef struct {
        logic [VADDR_W-1:0] pc;
        logic               taken;
        logic               mispred;
        logic [1:0]         bim;
        int                 avail;   // first cycle the entry is visible
    } exp_t;

    exp_t       q[$];
    logic [1:0] issued_bim[$];
    int         cyc = 0;
    int         n_checks = 0;
    int         n_pass = 0;

    bit               prev_v = 1'b0;
    logic [IW-1:0]    prev_idx = '0;
    logic [1:0]       prev_val = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    // Saturating-when-correct counter, modulo-4 stepping otherwise.
    function automatic logic [1:0] ref_next(input int v, input bit hit, input bit taken);
        int r;
        if (hit && (v == 0 || v == 3)) r = v;
        else if (taken) r = (v + 1) % 4;
        else r = (v + 3) % 4;
        return r[1:0];
    endfunction

    // Monitor: occupancy is the number of accepted entries already written.
    always @(negedge clk) begin
        int            occ;
        exp_t          e;
        logic [IW-1:0] idx;
        logic [1:0]    expb;
        occ = 0;
        foreach (q[k]) if (q[k].avail <= cyc) occ++;
        chk("valid", 64'(upd_valid), 64'(occ > 0));
        chk("ready", 64'(br_ready), 64'((DEPTH - occ) >= BRW));
        chk("empty", 64'(fifo_empty), 64'(occ == 0));
        if (upd_valid && occ > 0) begin
            e    = q.pop_front();
            idx  = e.pc[IW:1];
            expb = (FWD && prev_v && prev_idx == idx) ? prev_val : e.bim;
            chk("pc", 64'(upd_pc), 64'(e.pc));
            chk("taken", 64'(upd_taken), 64'(e.taken));
            chk("hit", 64'(upd_hit), 64'(!e.mispred));
            chk("bim_value", 64'(upd_bim), 64'(expb));
            issued_bim.push_back(upd_bim);
            prev_v   = 1'b1;
            prev_idx = idx;
            prev_val = ref_next(int'(expb), !e.mispred, e.taken);
        end else begin
            prev_v = 1'b0;
        end
        if (rst) begin
            q.delete();
            prev_v = 1'b0;
        end
    end

    task automatic drive(input logic [1:0] v, input logic [VADDR_W-1:0] p0,
                         input logic [VADDR_W-1:0] p1, input logic [1:0] tk,
                         input logic [1:0] mp, input logic [1:0] b0, input logic [1:0] b1);
        exp_t e;
        logic [VADDR_W-1:0] pcs [2];
        logic [1:0]         bs [2];
        @(posedge clk); #1;
        if (!br_ready) v = 2'b00;
        pcs[0] = p0; pcs[1] = p1; bs[0] = b0; bs[1] = b1;
        br_valid = v; br_taken = tk; br_mispred = mp;
        for (int s = 0; s < BRW; s++) begin
            br_pc[s]  = pcs[s];
            br_bim[s] = bs[s];
            if (v[s]) begin
                e.pc = pcs[s]; e.taken = tk[s]; e.mispred = mp[s]; e.bim = bs[s];
                e.avail = cyc + 1;
                q.push_back(e);
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(2'b00, '0, '0, 2'b00, 2'b00, 2'b00, 2'b00);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; br_valid = '0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        logic [VADDR_W-1:0] p0, p1;
        logic [1:0] exp2;
        int waited;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Single branch: pc 0x104, taken, mispredicted, counter 01.
        issued_bim.delete();
        drive(2'b01, VADDR_W'('h104), '0, 2'b01, 2'b01, 2'b01, 2'b00);
        idle(3);
        chk("single_count", 64'(issued_bim.size()), 64'd1);
        if (issued_bim.size() > 0) chk("single_bim", 64'(issued_bim[0]), 64'd1);

        // Dual input in one cycle, then a full-queue burst.
        drive(2'b11, VADDR_W'('h200), VADDR_W'('h208), 2'b00, 2'b00, 2'b10, 2'b10);
        idle(3);
        drive(2'b11, VADDR_W'('h300), VADDR_W'('h304), 2'b11, 2'b00, 2'b11, 2'b11);
        drive(2'b11, VADDR_W'('h308), VADDR_W'('h30c), 2'b10, 2'b01, 2'b00, 2'b01);
        idle(6);

        // Same-index pair, counter 01: second forwarded to 10 when enabled.
        issued_bim.delete();
        drive(2'b11, VADDR_W'('h10), VADDR_W'('h10), 2'b11, 2'b00, 2'b01, 2'b01);
        idle(3);
        exp2 = FWD ? 2'b10 : 2'b01;
        chk("fwd_count", 64'(issued_bim.size()), 64'd2);
        if (issued_bim.size() == 2) begin
            chk("fwd_first", 64'(issued_bim[0]), 64'd1);
            chk("fwd_second", 64'(issued_bim[1]), 64'(exp2));
        end

        // Saturated pair: counter 11 with a hit holds.
        issued_bim.delete();
        drive(2'b11, VADDR_W'('h10), VADDR_W'('h10), 2'b11, 2'b00, 2'b11, 2'b11);
        idle(3);
        chk("sat_count", 64'(issued_bim.size()), 64'd2);
        if (issued_bim.size() == 2) begin
            chk("sat_first", 64'(issued_bim[0]), 64'd3);
            chk("sat_second", 64'(issued_bim[1]), 64'd3);
        end

        // Reset while three entries are queued.
        drive(2'b11, VADDR_W'('h400), VADDR_W'('h404), 2'b01, 2'b10, 2'b01, 2'b10);
        drive(2'b11, VADDR_W'('h408), VADDR_W'('h40c), 2'b10, 2'b01, 2'b00, 2'b11);
        do_reset();
        @(negedge clk);
        chk("rst_valid", 64'(upd_valid), 64'd0);
        chk("rst_empty", 64'(fifo_empty), 64'd1);
        chk("rst_ready", 64'(br_ready), 64'd1);

        // Random traffic over a small index set so forwarding triggers often.
        for (int i = 0; i < 1500; i++) begin
            p0 = VADDR_W'({$urandom(), $urandom()});
            p1 = VADDR_W'({$urandom(), $urandom()});
            p0[IW:1] = IW'($urandom_range(0, 3));
            p1[IW:1] = IW'($urandom_range(0, 3));
            if ($urandom_range(0, 99) == 0) do_reset();
            else drive(2'($urandom_range(0, 3)), p0, p1, 2'($urandom()), 2'($urandom()),
                       2'($urandom()), 2'($urandom()));
        end

        waited = 0;
        while (q.size() > 0 && waited < 20) begin
            idle(1);
            waited++;
        end
        idle(1);
        chk("drain", 64'(q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
